ghost_mode_sched: RTL and testbench

GHOST_MODE_SCHED -- requirements
Module: ghost_mode_sched

---
 rtl/ghost_mode_sched.sv | 129 ++++++++++++
 tb/tb_ghost_mode_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ghost_mode_sched.sv
// ghost_mode_sched: scatter/chase/frightened mode scheduler for the ghost AI.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   tick         : one-cycle 60 Hz movement strobe
//   game_start   : one-cycle pulse, (re)starts the schedule from phase 0
//   power_pellet : one-cycle pulse, energizer eaten
//   isScatter    : ghosts target their corners
//   isChase      : ghosts target their chase tiles
//   isFrightened : frightened mode
//   reverse      : one-cycle pulse, all ghosts reverse direction
//   phase        : current schedule phase 0..7 (7 = endless chase)
//   releaseFlags : sticky per-ghost house-release flags
module ghost_mode_sched #(
   parameter int SCAT_LONG  = 420,
   parameter int SCAT_SHORT = 300,
   parameter int CHASE_LEN  = 1200,
   parameter int FRIGHT_LEN = 360,
   parameter int REL1       = 60,
   parameter int REL2       = 240,
   parameter int REL3       = 300
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       game_start,
   input  logic       power_pellet,
   output logic       isScatter,
   output logic       isChase,
   output logic       isFrightened,
   output logic       reverse,
   output logic [2:0] phase,
   output logic [3:0] releaseFlags
);
   typedef enum logic [1:0] {IDLE, RUN, FRIGHT} stateType;

   localparam logic [10:0] LONG_LEN  = 11'(SCAT_LONG);
   localparam logic [10:0] SHORT_LEN = 11'(SCAT_SHORT);
   localparam logic [10:0] CHASE_L   = 11'(CHASE_LEN);
   localparam logic [8:0]  FRIGHT_L  = 9'(FRIGHT_LEN);
   localparam logic [8:0]  R1        = 9'(REL1);
   localparam logic [8:0]  R2        = 9'(REL2);
   localparam logic [8:0]  R3        = 9'(REL3);

   stateType    state;
   logic [10:0] phaseTimer;
   logic [8:0]  frightTimer;
   logic [8:0]  relCnt;
   logic [10:0] phaseLen;
   logic [10:0] phaseInc;
   logic [8:0]  relNext;
   logic [3:0]  relSet;
   logic        lastPhase;

   always_comb begin
      phaseLen  = phase[0] ? CHASE_L : (phase < 3'd4 ? LONG_LEN : SHORT_LEN);
      phaseInc  = phaseTimer + 11'd1;
      lastPhase = phase == 3'd7;
      relNext   = (relCnt == 9'd511) ? relCnt : relCnt + 9'd1;
      relSet    = {relNext >= R3, relNext >= R2, relNext >= R1, 1'b0};
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state        <= IDLE;
         phase        <= 3'd0;
         phaseTimer   <= 11'd0;
         frightTimer  <= 9'd0;
         relCnt       <= 9'd0;
         releaseFlags <= 4'b0000;
         reverse      <= 1'b0;
         isScatter    <= 1'b0;
         isChase      <= 1'b0;
         isFrightened <= 1'b0;
      end else begin
         reverse <= 1'b0;
         if (game_start) begin
            state        <= RUN;
            phase        <= 3'd0;
            phaseTimer   <= 11'd0;
            frightTimer  <= 9'd0;
            relCnt       <= 9'd0;
            releaseFlags <= 4'b0001;
            isScatter    <= 1'b1;
            isChase      <= 1'b0;
            isFrightened <= 1'b0;
         end else begin
            // release counting keeps running while frightened
            if (state != IDLE && tick) begin
               relCnt       <= relNext;
               releaseFlags <= releaseFlags | relSet;
            end
            case (state)
               RUN:
                  // a pellet swallows any coincident phase advance; its own reverse is the only one
                  if (power_pellet) begin
                     state        <= FRIGHT;
                     frightTimer  <= FRIGHT_L;
                     reverse      <= 1'b1;
                     isScatter    <= 1'b0;
                     isChase      <= 1'b0;
                     isFrightened <= 1'b1;
                  end else if (tick && !lastPhase) begin
                     if (phaseInc == phaseLen) begin
                        // next phase has the opposite parity of the current one
                        phaseTimer <= 11'd0;
                        phase      <= phase + 3'd1;
                        reverse    <= 1'b1;
                        isScatter  <= phase[0];
                        isChase    <= ~phase[0];
                     end else
                        phaseTimer <= phaseInc;
                  end
               FRIGHT:
                  if (power_pellet)
                     frightTimer <= FRIGHT_L;
                  else if (tick) begin
                     frightTimer <= frightTimer - 9'd1;
                     if (frightTimer == 9'd1) begin
                        state        <= RUN;
                        isFrightened <= 1'b0;
                        isScatter    <= ~phase[0];
                        isChase      <= phase[0];
                     end
                  end
               default: ;
            endcase
         end
      end
endmodule

// File: tb/tb_ghost_mode_sched.sv
// tb_ghost_mode_sched: directed vector table plus multi-cycle scenarios for ghost_mode_sched.
module tb_ghost_mode_sched;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       game_start = 1'b0;
   logic       power_pellet = 1'b0;
   logic       isScatter, isChase, isFrightened, reverse;
   logic [2:0] phase;
   logic [3:0] releaseFlags;
   int         total = 0;
   int         bad = 0;
   int         revCount = 0;

   typedef struct {
      logic       t, g, p;
      logic       s, c, f, r;
      logic [2:0] ph;
      logic [3:0] rel;
   } vecType;
   vecType vecs[10];

   ghost_mode_sched dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .game_start(game_start),
      .power_pellet(power_pellet), .isScatter(isScatter), .isChase(isChase),
      .isFrightened(isFrightened), .reverse(reverse), .phase(phase),
      .releaseFlags(releaseFlags)
   );

   always #20 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic t, input logic g, input logic p);
      @(negedge clk);
      tick = t;
      game_start = g;
      power_pellet = p;
      @(posedge clk);
      #1;
      tick = 1'b0;
      game_start = 1'b0;
      power_pellet = 1'b0;
      if (reverse) revCount++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int   rev0;
      logic ok;
      vecs[0] = '{t:0, g:0, p:0, s:0, c:0, f:0, r:0, ph:0, rel:4'b0000};
      vecs[1] = '{t:1, g:0, p:0, s:0, c:0, f:0, r:0, ph:0, rel:4'b0000};
      vecs[2] = '{t:0, g:0, p:1, s:0, c:0, f:0, r:0, ph:0, rel:4'b0000};
      vecs[3] = '{t:1, g:1, p:1, s:1, c:0, f:0, r:0, ph:0, rel:4'b0001};
      vecs[4] = '{t:1, g:0, p:0, s:1, c:0, f:0, r:0, ph:0, rel:4'b0001};
      vecs[5] = '{t:1, g:0, p:1, s:0, c:0, f:1, r:1, ph:0, rel:4'b0001};
      vecs[6] = '{t:0, g:0, p:1, s:0, c:0, f:1, r:0, ph:0, rel:4'b0001};
      vecs[7] = '{t:1, g:0, p:0, s:0, c:0, f:1, r:0, ph:0, rel:4'b0001};
      vecs[8] = '{t:1, g:1, p:0, s:1, c:0, f:0, r:0, ph:0, rel:4'b0001};
      vecs[9] = '{t:0, g:0, p:0, s:1, c:0, f:0, r:0, ph:0, rel:4'b0001};

      doReset();
      #1;
      chk("reset_outs", {isScatter, isChase, isFrightened, reverse, phase, releaseFlags}, 0);
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].t, vecs[i].g, vecs[i].p);
         chk($sformatf("vec%0d", i),
             {isScatter, isChase, isFrightened, reverse, phase, releaseFlags},
             {vecs[i].s, vecs[i].c, vecs[i].f, vecs[i].r, vecs[i].ph, vecs[i].rel});
      end

      // first scatter phase and full schedule
      doReset();
      step(1'b0, 1'b1, 1'b0);
      rev0 = revCount;
      ok = 1'b1;
      for (int i = 1; i < 420; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (!isScatter || isChase || reverse || phase != 3'd0) ok = 1'b0;
      end
      chk("scatter_thru_419", ok, 1);
      step(1'b1, 1'b0, 1'b0);
      chk("t420_mode", {isScatter, isChase, reverse, phase}, {1'b0, 1'b1, 1'b1, 3'd1});
      chk("t420_revs", revCount - rev0, 1);
      ticks(5040 - 420);
      chk("full_mode", {isScatter, isChase, isFrightened, phase}, {1'b0, 1'b1, 1'b0, 3'd7});
      chk("full_revs", revCount - rev0, 7);
      chk("full_release", releaseFlags, 4'b1111);
      ticks(2000);
      chk("sat_mode", {isScatter, isChase, phase}, {1'b0, 1'b1, 3'd7});
      chk("sat_revs", revCount - rev0, 7);

      // pellet at phase timer 100, phase timer resumes after fright
      step(1'b0, 1'b1, 1'b0);
      rev0 = revCount;
      ticks(100);
      step(1'b0, 1'b0, 1'b1);
      ok = 1'b1;
      for (int i = 1; i < 360; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (!isFrightened || isScatter || isChase || reverse) ok = 1'b0;
      end
      chk("fright_359", ok, 1);
      step(1'b1, 1'b0, 1'b0);
      chk("fright_end", {isScatter, isChase, isFrightened, reverse, phase}, {1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
      chk("fright_revs", revCount - rev0, 1);
      ticks(319);
      chk("resume_319", {isScatter, phase}, {1'b1, 3'd0});
      step(1'b1, 1'b0, 1'b0);
      chk("resume_320", {isChase, phase}, {1'b1, 3'd1});
      chk("resume_revs", revCount - rev0, 2);

      // second pellet restarts the fright window
      step(1'b0, 1'b1, 1'b0);
      rev0 = revCount;
      step(1'b0, 1'b0, 1'b1);
      ticks(200);
      step(1'b0, 1'b0, 1'b1);
      ticks(359);
      chk("repellet_359", isFrightened, 1);
      step(1'b1, 1'b0, 1'b0);
      chk("repellet_end", {isFrightened, isScatter}, {1'b0, 1'b1});
      chk("repellet_revs", revCount - rev0, 1);

      // release flags while FRIGHT spans ticks 50..410
      step(1'b0, 1'b1, 1'b0);
      chk("rel_start", releaseFlags, 4'b0001);
      ticks(50);
      step(1'b0, 1'b0, 1'b1);
      ticks(9);
      chk("rel_59", releaseFlags, 4'b0001);
      ticks(1);
      chk("rel_60", releaseFlags, 4'b0011);
      ticks(179);
      chk("rel_239", releaseFlags, 4'b0011);
      ticks(1);
      chk("rel_240", releaseFlags, 4'b0111);
      ticks(59);
      chk("rel_299", {releaseFlags, isFrightened}, {4'b0111, 1'b1});
      ticks(1);
      chk("rel_300", {releaseFlags, isFrightened}, {4'b1111, 1'b1});
      ticks(110);
      chk("rel_410", {releaseFlags, isFrightened, isScatter}, {4'b1111, 1'b0, 1'b1});

      // pellet with tick still counts release
      step(1'b0, 1'b1, 1'b0);
      ticks(59);
      step(1'b1, 1'b0, 1'b1);
      chk("pellet_tick_rel", {releaseFlags, isFrightened}, {4'b0011, 1'b1});

      // pellet coinciding with phase expiry: one reverse, phase held
      step(1'b0, 1'b1, 1'b0);
      rev0 = revCount;
      ticks(419);
      step(1'b1, 1'b0, 1'b1);
      chk("expiry_pellet", {isFrightened, reverse, phase}, {1'b1, 1'b1, 3'd0});
      ticks(360);
      chk("expiry_back", {isScatter, phase, revCount - rev0}, {1'b1, 3'd0, 32'd1});
      step(1'b1, 1'b0, 1'b0);
      chk("expiry_adv", {isChase, phase, revCount - rev0}, {1'b1, 3'd1, 32'd2});

      // asynchronous reset mid-fright
      step(1'b0, 1'b1, 1'b0);
      ticks(80);
      step(1'b0, 1'b0, 1'b1);
      ticks(30);
      @(posedge clk);
      #5;
      reset_n = 1'b0;
      #1;
      chk("async_reset", {isScatter, isChase, isFrightened, reverse, phase, releaseFlags}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      ticks(5);
      step(1'b0, 1'b0, 1'b1);
      chk("idle_after_reset", {isScatter, isChase, isFrightened, reverse, phase, releaseFlags}, 0);

      // restart from mid-phase 3
      step(1'b0, 1'b1, 1'b0);
      ticks(2040 + 100);
      chk("mid_phase3", {isChase, phase}, {1'b1, 3'd3});
      step(1'b1, 1'b1, 1'b1);
      chk("restart", {isScatter, isChase, isFrightened, reverse, phase, releaseFlags},
          {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0001});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
